// File: rtl/shift_capture_pkg.sv
// Shared definitions for the shift_capture block.
//   - Default frame length and FIFO depth
//   - Wishbone register map (word addresses on i_wb_addr)
//   - STATUS and CONTROL bit positions
//   - Sticky error flag bundle and frame mask helper
package shift_capture_pkg;

  localparam int unsigned FRAME_BITS_DEFAULT = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

  // Width of the serial bit counter; counts saturate at 63.
  localparam int unsigned BIT_CNT_W = 6;

  // Register map
  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_DATA      = 3'd1;
  localparam logic [2:0] ADDR_CONTROL   = 3'd2;
  localparam logic [2:0] ADDR_BITCOUNT  = 3'd3;
  localparam logic [2:0] ADDR_ACCEPTED  = 3'd4;
  localparam logic [2:0] ADDR_DISCARDED = 3'd5;

  // STATUS layout
  localparam int unsigned STATUS_COUNT_LSB   = 0;
  localparam int unsigned STATUS_COUNT_W     = 8;
  localparam int unsigned STATUS_EMPTY_BIT   = 8;
  localparam int unsigned STATUS_FULL_BIT    = 9;
  localparam int unsigned STATUS_OVF_BIT     = 10;
  localparam int unsigned STATUS_LEN_ERR_BIT = 11;

  // CONTROL layout
  localparam int unsigned CTRL_CLEAR_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;

  typedef struct packed {
    logic ovf;
    logic len_err;
  } sticky_t;

  // Ones in the low 'bits' positions of a 32-bit word.
  function automatic logic [31:0] frame_mask(input int unsigned bits);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO holding captured frames.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   i_push, i_wdata - write request and data; ignored when full unless popped same cycle
//   i_pop           - read request; ignored when empty
//   i_flush         - empties the FIFO; a same-cycle push is discarded
//   o_rdata         - head entry (undefined when empty)
//   o_count         - number of stored entries
//   o_full, o_empty - occupancy flags
module capture_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !reset) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/shift_capture.sv
// Captures frames shifted out by a matrix serializer and exposes them over Wishbone.
// The asynchronous matrix clock/latch/data are synchronized, edge-detected, and
// assembled MSB-first; each latch rise pushes the frame into a FIFO when exactly
// FRAME_BITS bits were shifted, otherwise flags a length error.
// Ports:
//   clk, reset                     - system clock, synchronous active-high reset
//   i_matrix_clk/latch/mosi        - asynchronous serializer inputs
//   i_wb_*                         - Wishbone slave request (cyc, stb, we, addr, sel, wdata)
//   o_wb_ack, o_wb_stall, o_wb_rdata - Wishbone response (ack one cycle after request)
//   o_frame_valid                  - FIFO holds at least one frame
// Optional build macro SHIFT_CAPTURE_STATS_EN adds accepted/discarded frame counters
// at addresses 4 and 5.
module shift_capture
  import shift_capture_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_matrix_clk,
  input  logic        i_matrix_latch,
  input  logic        i_matrix_mosi,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_addr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_wdata,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_rdata,
  output logic        o_frame_valid
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] FRAME_MASK = frame_mask(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;

  // Synchronizers and edge detectors
  logic [1:0] r_clk_sync;
  logic [1:0] r_latch_sync;
  logic [1:0] r_mosi_sync;
  logic       r_clk_prev;
  logic       r_latch_prev;
  logic       w_clk_rise;
  logic       w_latch_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync   <= '0;
      r_latch_sync <= '0;
      r_mosi_sync  <= '0;
      r_clk_prev   <= 1'b0;
      r_latch_prev <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_matrix_clk};
      r_latch_sync <= {r_latch_sync[0], i_matrix_latch};
      r_mosi_sync  <= {r_mosi_sync[0], i_matrix_mosi};
      r_clk_prev   <= r_clk_sync[1];
      r_latch_prev <= r_latch_sync[1];
    end
  end

  assign w_clk_rise   = r_clk_sync[1] & ~r_clk_prev;
  assign w_latch_rise = r_latch_sync[1] & ~r_latch_prev;

  // Frame assembly. The "effective" values fold in a same-cycle shift so a
  // coincident latch sees the bit that arrived with it.
  logic [31:0]          r_shift;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BIT_CNT_W-1:0] r_last_cnt;
  logic [31:0]          w_shift_eff;
  logic [BIT_CNT_W-1:0] w_cnt_eff;
  logic                 w_len_ok;
  logic                 w_cap_push;
  logic                 w_len_err_evt;

  always_comb begin
    w_shift_eff = r_shift;
    w_cnt_eff   = r_bit_cnt;
    if (w_clk_rise) begin
      w_shift_eff = {r_shift[30:0], r_mosi_sync[1]};
      if (r_bit_cnt != BIT_CNT_MAX) w_cnt_eff = r_bit_cnt + 1'b1;
    end
  end

  assign w_len_ok      = (w_cnt_eff == FRAME_LEN);
  assign w_cap_push    = w_latch_rise & w_len_ok;
  assign w_len_err_evt = w_latch_rise & ~w_len_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_last_cnt <= '0;
    end else begin
      r_shift <= w_shift_eff;
      if (w_latch_rise) begin
        r_bit_cnt  <= '0;
        r_last_cnt <= w_cnt_eff;
      end else begin
        r_bit_cnt <= w_cnt_eff;
      end
    end
  end

  // Wishbone request decode
  logic w_req;
  logic w_rd;
  logic w_ctrl_wr;
  logic w_clear;
  logic w_flush;
  logic w_pop;

  assign w_req     = i_wb_cyc & i_wb_stb;
  assign w_rd      = w_req & ~i_wb_we;
  assign w_ctrl_wr = w_req & i_wb_we & (i_wb_addr == ADDR_CONTROL) & i_wb_sel[0];
  assign w_clear   = w_ctrl_wr & i_wb_wdata[CTRL_CLEAR_BIT];
  assign w_flush   = w_ctrl_wr & i_wb_wdata[CTRL_FLUSH_BIT];

  // FIFO
  logic             w_fifo_push;
  logic [31:0]      w_fifo_rdata;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_ovf_evt;
  logic             w_acc_evt;

  assign w_pop       = w_rd & (i_wb_addr == ADDR_DATA) & ~w_fifo_empty;
  assign w_fifo_push = w_cap_push & ~w_flush;
  assign w_ovf_evt   = w_fifo_push & w_fifo_full & ~w_pop;
  assign w_acc_evt   = w_fifo_push & ~w_ovf_evt;

  capture_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_fifo_push),
    .i_wdata (w_shift_eff & FRAME_MASK),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_frame_valid = ~w_fifo_empty;

  // Sticky flags; a new event in the clearing cycle wins over the clear.
  sticky_t r_sticky;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= '0;
    end else begin
      r_sticky.ovf     <= (r_sticky.ovf & ~w_clear) | w_ovf_evt;
      r_sticky.len_err <= (r_sticky.len_err & ~w_clear) | w_len_err_evt;
    end
  end

`ifdef SHIFT_CAPTURE_STATS_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_disc_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_acc_cnt  <= '0;
      r_disc_cnt <= '0;
    end else begin
      if (w_acc_evt && r_acc_cnt != 16'hFFFF) r_acc_cnt <= r_acc_cnt + 16'd1;
      // Length errors and overflows never coincide: overflow needs a good length.
      if ((w_len_err_evt || w_ovf_evt) && r_disc_cnt != 16'hFFFF) begin
        r_disc_cnt <= r_disc_cnt + 16'd1;
      end
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = w_acc_evt;
`endif

  // Read mux; zero whenever no read is in flight so rdata idles at 0.
  logic [31:0] w_rdata_d;

  always_comb begin
    w_rdata_d = '0;
    if (w_rd) begin
      case (i_wb_addr)
        ADDR_STATUS: begin
          w_rdata_d[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_fifo_count);
          w_rdata_d[STATUS_EMPTY_BIT]   = w_fifo_empty;
          w_rdata_d[STATUS_FULL_BIT]    = w_fifo_full;
          w_rdata_d[STATUS_OVF_BIT]     = r_sticky.ovf;
          w_rdata_d[STATUS_LEN_ERR_BIT] = r_sticky.len_err;
        end
        ADDR_DATA: begin
          if (!w_fifo_empty) w_rdata_d = w_fifo_rdata;
        end
        ADDR_BITCOUNT: w_rdata_d[BIT_CNT_W-1:0] = r_last_cnt;
`ifdef SHIFT_CAPTURE_STATS_EN
        ADDR_ACCEPTED:  w_rdata_d[15:0] = r_acc_cnt;
        ADDR_DISCARDED: w_rdata_d[15:0] = r_disc_cnt;
`endif
        default: w_rdata_d = '0;
      endcase
    end
  end

  logic        r_ack;
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rdata_d;
    end
  end

  assign o_wb_ack   = r_ack;
  assign o_wb_rdata = r_rdata;
  assign o_wb_stall = 1'b0;

  logic w_unused;
  assign w_unused = ^{i_wb_wdata[31:2], i_wb_sel[3:1]};

endmodule

// File: tb/tb_shift_capture.sv
// Directed self-checking bench for shift_capture (default parameters).
module tb_shift_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_clk = 1'b0;
  logic        m_latch = 1'b0;
  logic        m_mosi = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_ack;
  logic        wb_stall;
  logic [31:0] wb_rdata;
  logic        frame_valid;

  int n_checks = 0;
  int n_errors = 0;
  bit stall_seen = 1'b0;
  int last_lat;
  logic [31:0] rd;

  always #5 clk = ~clk;

  shift_capture dut (
    .clk            (clk),
    .reset          (reset),
    .i_matrix_clk   (m_clk),
    .i_matrix_latch (m_latch),
    .i_matrix_mosi  (m_mosi),
    .i_wb_cyc       (wb_cyc),
    .i_wb_stb       (wb_stb),
    .i_wb_we        (wb_we),
    .i_wb_addr      (wb_addr),
    .i_wb_sel       (wb_sel),
    .i_wb_wdata     (wb_wdata),
    .o_wb_ack       (wb_ack),
    .o_wb_stall     (wb_stall),
    .o_wb_rdata     (wb_rdata),
    .o_frame_valid  (frame_valid)
  );

  always @(negedge clk) if (wb_stall !== 1'b0) stall_seen = 1'b1;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    m_mosi = b;
    tick(3);
    m_clk = 1'b1;
    tick(3);
    m_clk = 1'b0;
    tick(3);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic latch_pulse();
    m_latch = 1'b1;
    tick(3);
    m_latch = 1'b0;
    tick(4);
  endtask

  // Single-cycle strobe; waits a bounded number of cycles for ack.
  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [3:0] sel,
                         input logic [31:0] wd, output logic [31:0] d);
    int n;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_sel = sel; wb_wdata = wd;
    tick();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    n = 1;
    while (wb_ack !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    d = wb_rdata;
    last_lat = n;
    check("ack_latency", 32'(n), 32'd1);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 4'hF, 32'h0, d);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [3:0] sel, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, sel, wd, dummy);
  endtask

  logic [31:0] frames [9] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                              32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888,
                              32'h9999_9999};

  initial begin
    // Reset state
    tick(2);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_rdata", wb_rdata, 32'h0);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd0);
    reset = 1'b0;
    tick();
    wb_read(3'd0, rd);
    check("rst_status", rd, 32'h0000_0100);

    // Single 32-bit frame
    send_bits(32'hA5C3_0F81, 32);
    latch_pulse();
    check("f1_valid", 32'(frame_valid), 32'd1);
    wb_read(3'd0, rd);
    check("f1_status", rd, 32'h0000_0001);
    wb_read(3'd1, rd);
    check("f1_data", rd, 32'hA5C3_0F81);
    wb_read(3'd0, rd);
    check("f1_status_empty", rd, 32'h0000_0100);

    // Short frame -> length error
    send_bits(32'h1234_5678, 31);
    latch_pulse();
    wb_read(3'd0, rd);
    check("short_status", rd, 32'h0000_0900);
    wb_read(3'd3, rd);
    check("short_bitcount", rd, 32'd31);
`ifdef SHIFT_CAPTURE_STATS_EN
    wb_read(3'd4, rd);
    check("stats_accepted", rd, 32'd1);
    wb_read(3'd5, rd);
    check("stats_discarded", rd, 32'd1);
`endif
    wb_write(3'd2, 4'hE, 32'h1);  // sel[0]=0: ignored
    wb_read(3'd0, rd);
    check("clear_nosel", rd, 32'h0000_0900);
    wb_write(3'd2, 4'h1, 32'h1);
    wb_read(3'd0, rd);
    check("clear_status", rd, 32'h0000_0100);

    // Overflow: nine frames, no reads
    for (int i = 0; i < 9; i++) begin
      send_bits(frames[i], 32);
      latch_pulse();
    end
    wb_read(3'd0, rd);
    check("ovf_status", rd, 32'h0000_0608);
    for (int i = 0; i < 8; i++) begin
      wb_read(3'd1, rd);
      check($sformatf("ovf_data%0d", i + 1), rd, frames[i]);
    end
    wb_read(3'd0, rd);
    check("ovf_drained", rd, 32'h0000_0500);
    wb_write(3'd2, 4'h1, 32'h1);

    // Last clock rise coincides with latch rise
    send_bits(32'h0F0F_F0F1 >> 1, 31);
    m_mosi = 1'b1;
    tick(3);
    m_clk = 1'b1;
    m_latch = 1'b1;
    tick(3);
    m_clk = 1'b0;
    m_latch = 1'b0;
    tick(4);
    wb_read(3'd0, rd);
    check("coinc_status", rd, 32'h0000_0001);
    wb_read(3'd1, rd);
    check("coinc_data", rd, 32'h0F0F_F0F1);
    check("coinc_lsb", 32'(rd[0]), 32'd1);

    // Reset mid-frame, then a clean frame
    send_bits(32'h0000_BEEF, 16);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    send_bits(32'hDEAD_BEEF, 32);
    latch_pulse();
    wb_read(3'd0, rd);
    check("rstmid_status", rd, 32'h0000_0001);
    wb_read(3'd1, rd);
    check("rstmid_data", rd, 32'hDEAD_BEEF);

    // Empty read, ack width, unused address, ignored write, flush
    wb_read(3'd1, rd);
    check("empty_data", rd, 32'h0);
    check("empty_lat", 32'(last_lat), 32'd1);
    tick();
    check("ack_one_cycle", 32'(wb_ack), 32'd0);
    check("rdata_idle", wb_rdata, 32'h0);
    wb_read(3'd6, rd);
    check("unused_addr", rd, 32'h0);
    send_bits(32'hCAFE_F00D, 32);
    latch_pulse();
    wb_write(3'd0, 4'hF, 32'hFFFF_FFFF);
    wb_read(3'd0, rd);
    check("ro_write_ignored", rd, 32'h0000_0001);
    wb_write(3'd2, 4'h1, 32'h2);
    wb_read(3'd0, rd);
    check("flush_status", rd, 32'h0000_0100);
    check("stall_never", 32'(stall_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
